// File: rtl/match_scorekeeper.sv
// Match scorekeeper: tallies round wins per player, shows both scores on
// 7-segment digits, times the post-round display hold, pulses round_reset
// to recentre the playfield, and ends the match at MAX_SCORE.
//
// Ports:
//   clk          system clock (CLOCK_50), all state changes on posedge
//   reset        asynchronous, active-low
//   clear        synchronous, active-high; start a new match
//   win_L        one-cycle pulse, left player won the round
//   win_R        one-cycle pulse, right player won the round
//   round_reset  one-cycle pulse, recentres the playfield
//   game_over    high while the match is over
//   hex_L/hex_R  active-low 7-seg digits (gfedcba) showing the scores
module match_scorekeeper #(
  parameter int unsigned MAX_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       win_L,
  input  logic       win_R,
  output logic       round_reset,
  output logic       game_over,
  output logic [6:0] hex_L,
  output logic [6:0] hex_R
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = $clog2(HOLD_CYCLES + 1);

  localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [6:0]         SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    RESTART    = 2'd2,
    MATCH_OVER = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [SCORE_W-1:0]   score_l, score_l_nxt;
  logic [SCORE_W-1:0]   score_r, score_r_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [SCORE_W-1:0]   win_score;

  logic                 round_reset_nxt;
  logic                 game_over_nxt;
  logic [6:0]           hex_l_nxt;
  logic [6:0]           hex_r_nxt;

  // Active-low gfedcba segment pattern for one decimal digit
  function automatic logic [6:0] seg7(input logic [SCORE_W-1:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= PLAY;
      score_l <= '0;
      score_r <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      score_l <= score_l_nxt;
      score_r <= score_r_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Score the winning side would reach if this cycle's win is accepted
  assign win_score = win_L ? (score_l + SCORE_W'(1)) : (score_r + SCORE_W'(1));

  // Next-state and datapath update; clear overrides everything
  always_comb begin
    state_nxt   = state;
    score_l_nxt = score_l;
    score_r_nxt = score_r;
    cnt_nxt     = cnt;
    if (clear) begin
      state_nxt   = RESTART;
      score_l_nxt = '0;
      score_r_nxt = '0;
      cnt_nxt     = '0;
    end else begin
      case (state)
        PLAY: begin
          // Simultaneous wins cancel out
          if (win_L ^ win_R) begin
            if (win_L) score_l_nxt = win_score;
            else       score_r_nxt = win_score;
            if (win_score == MAX_S) begin
              state_nxt = MATCH_OVER;
            end else begin
              state_nxt = HOLD;
              cnt_nxt   = '0;
            end
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) state_nxt = RESTART;
          else                  cnt_nxt   = cnt + CNT_W'(1);
        end
        RESTART:    state_nxt = PLAY;
        MATCH_OVER: state_nxt = MATCH_OVER;
        default:    state_nxt = PLAY;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs track it
  always_comb begin
    round_reset_nxt = 1'b0;
    game_over_nxt   = 1'b0;
    hex_l_nxt       = seg7(score_l_nxt);
    hex_r_nxt       = seg7(score_r_nxt);
    if (state_nxt == RESTART)    round_reset_nxt = 1'b1;
    if (state_nxt == MATCH_OVER) game_over_nxt   = 1'b1;
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_reset <= 1'b0;
      game_over   <= 1'b0;
      hex_L       <= SEG_ZERO;
      hex_R       <= SEG_ZERO;
    end else begin
      round_reset <= round_reset_nxt;
      game_over   <= game_over_nxt;
      hex_L       <= hex_l_nxt;
      hex_R       <= hex_r_nxt;
    end
  end

endmodule

// File: tb/tb_match_scorekeeper.sv
// Self-checking bench for match_scorekeeper (MAX_SCORE=3, HOLD_CYCLES=4).
module tb_match_scorekeeper;

  localparam int unsigned MAX_SCORE   = 3;
  localparam int unsigned HOLD_CYCLES = 4;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       win_L;
  logic       win_R;
  logic       round_reset;
  logic       game_over;
  logic [6:0] hex_L;
  logic [6:0] hex_R;

  typedef struct packed {
    logic       rr;
    logic       go;
    logic [6:0] hl;
    logic [6:0] hr;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_l, m_r;
  int m_hold;   // remaining HOLD cycles, 0 when not holding
  bit m_rr;     // in the restart cycle
  bit m_over;

  match_scorekeeper #(
    .MAX_SCORE  (MAX_SCORE),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .win_L      (win_L),
    .win_R      (win_R),
    .round_reset(round_reset),
    .game_over  (game_over),
    .hex_L      (hex_L),
    .hex_R      (hex_R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_l = 0; m_r = 0; m_hold = 0; m_rr = 0; m_over = 0;
  endtask

  // One clock edge of the reference model
  task automatic model_edge(input bit wl, input bit wr, input bit clr);
    if (clr) begin
      m_l = 0; m_r = 0; m_hold = 0; m_over = 0; m_rr = 1;
    end else if (m_rr) begin
      m_rr = 0;
    end else if (m_hold > 0) begin
      if (m_hold == 1) begin
        m_hold = 0;
        m_rr   = 1;
      end else begin
        m_hold--;
      end
    end else if (!m_over && (wl != wr)) begin
      if (wl) m_l++; else m_r++;
      if (m_l == int'(MAX_SCORE) || m_r == int'(MAX_SCORE)) m_over = 1;
      else m_hold = int'(HOLD_CYCLES);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rr = m_rr;
    e.go = m_over;
    e.hl = seg(m_l);
    e.hr = seg(m_r);
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".round_reset"}, 32'(round_reset), 32'(e.rr));
    check({tag, ".game_over"},   32'(game_over),   32'(e.go));
    check({tag, ".hex_L"},       32'(hex_L),       32'(e.hl));
    check({tag, ".hex_R"},       32'(hex_R),       32'(e.hr));
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge
  task automatic step(input string tag, input bit wl, input bit wr, input bit clr);
    exp_t e;
    @(negedge clk);
    win_L = wl;
    win_R = wr;
    clear = clr;
    model_edge(wl, wr, clr);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    win_L = 1'b0;
    win_R = 1'b0;
    model_reset();

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", model_out());
    @(negedge clk);
    reset = 1'b1;
    idle("post_reset", 2);

    // 2: single left win, full HOLD/RESTART timing
    step("winL1", 1'b1, 1'b0, 1'b0);
    idle("hold1", 6);

    // 3: ignored wins in HOLD, RESTART and simultaneous in PLAY
    step("winL2", 1'b1, 1'b0, 1'b0);
    step("winR_hold", 1'b0, 1'b1, 1'b0);
    idle("hold2", 3);
    step("winR_restart", 1'b0, 1'b1, 1'b0);
    step("both_play", 1'b1, 1'b1, 1'b0);
    idle("after_both", 2);

    // 4: right player takes the match
    for (int i = 0; i < 3; i++) begin
      step("winR", 1'b0, 1'b1, 1'b0);
      idle("gap", 6);
    end
    step("winL_over", 1'b1, 1'b0, 1'b0);
    idle("over", 3);

    // 5: clear from MATCH_OVER, then a normal win
    step("clear_over", 1'b0, 1'b0, 1'b1);
    idle("clear_rr", 1);
    step("winL_after_clear", 1'b1, 1'b0, 1'b0);
    idle("hold3", 6);
    step("clear_vs_win", 1'b1, 1'b0, 1'b1);
    idle("clear_rr2", 2);

    // 6: reset mid-HOLD, no clock edge before the check
    step("winL_pre_rst", 1'b1, 1'b0, 1'b0);
    idle("hold4", 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst", model_out());
    @(negedge clk);
    reset = 1'b1;
    idle("no_rr_after_rst", 10);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 60) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
